// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the serial link transmit/receive paths.
// State encoding, default frame geometry and counter width.
package uart_pkg;

    localparam int CNT_W            = 11;
    localparam int DEF_DATA_LENGTH  = 8;
    localparam int DEF_DUMMY_PERIOD = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;

    // Terminal value of a 0-based counter that must cover n steps.
    function automatic logic [CNT_W-1:0] last_index(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts 0..PERIOD-1 and strobes o_bit_end on the last count.
// Held at zero while i_clear is high; shared by transmit and receive paths.
module bit_timer
    import uart_pkg::*;
#(
    parameter int PERIOD = DEF_DUMMY_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] LAST = last_index(PERIOD);

    logic [CNT_W-1:0] r_count;

    assign o_bit_end = (r_count == LAST) && !i_clear;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (o_bit_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/transmitter.sv
// transmitter: UART-style serial transmitter, line idles high.
// Sends start bit, data_length bits LSB first, then stop_bits stop bits.
module transmitter
    import uart_pkg::*;
#(
    parameter int data_length  = DEF_DATA_LENGTH,
    parameter int dummy_period = DEF_DUMMY_PERIOD,
    parameter int stop_bits    = 1
) (
    input  logic                   clk,
    input  logic                   prst,
    input  logic                   start,
    input  logic [data_length-1:0] parallel_in,
    output logic                   serial_out,
    output logic                   busy,
    output logic                   done
);

    localparam logic [CNT_W-1:0] LAST_BIT  = last_index(data_length);
    localparam logic [CNT_W-1:0] LAST_STOP = last_index(stop_bits);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [data_length-1:0] r_shreg;
    logic [data_length-1:0] w_shreg_nxt;
    logic [data_length-1:0] w_shifted;
    logic [CNT_W-1:0]       r_idx;
    logic [CNT_W-1:0]       w_idx_nxt;
    logic                   r_serial;
    logic                   w_serial_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_bit_end;
    logic                   w_timer_clr;
    logic                   w_last_data;
    logic                   w_last_stop;

    assign w_timer_clr = (r_state == ST_IDLE);
    assign w_shifted   = r_shreg >> 1;
    assign w_last_data = w_bit_end && (r_idx == LAST_BIT);
    assign w_last_stop = w_bit_end && (r_idx == LAST_STOP);

    bit_timer #(
        .PERIOD (dummy_period)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (prst),
        .i_clear   (w_timer_clr),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (prst) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_idx    <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_idx    <= w_idx_nxt;
            r_serial <= w_serial_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_last_data) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_last_stop) begin
                    w_state_nxt = start ? ST_START : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shreg_nxt  = r_shreg;
        w_idx_nxt    = r_idx;
        w_serial_nxt = r_serial;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (start) begin
                    w_shreg_nxt  = parallel_in;
                    w_idx_nxt    = '0;
                    w_serial_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) w_serial_nxt = r_shreg[0];
            end
            ST_DATA: begin
                if (w_last_data) begin
                    w_idx_nxt    = '0;
                    w_serial_nxt = 1'b1;
                end else if (w_bit_end) begin
                    w_shreg_nxt  = w_shifted;
                    w_serial_nxt = w_shifted[0];
                    w_idx_nxt    = r_idx + 1'b1;
                end
            end
            ST_STOP: begin
                // A held request restarts here so frames run back to back.
                if (w_last_stop) begin
                    w_done_nxt = 1'b1;
                    w_idx_nxt  = '0;
                    if (start) begin
                        w_shreg_nxt  = parallel_in;
                        w_serial_nxt = 1'b0;
                        w_busy_nxt   = 1'b1;
                    end else begin
                        w_busy_nxt = 1'b0;
                    end
                end else if (w_bit_end) begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: self-checking bench for transmitter.
// Expected line/busy/done come from a per-cycle timeline built from frame rules.
module tb_transmitter;

    logic       clk = 1'b0;
    logic       prst;
    logic       start_a;
    logic       start_b;
    logic [7:0] in_a;
    logic [4:0] in_b;
    wire        ser_a;
    wire        busy_a;
    wire        done_a;
    wire        ser_b;
    wire        busy_b;
    wire        done_b;

    always #5 clk = ~clk;

    transmitter u_a (
        .clk         (clk),
        .prst        (prst),
        .start       (start_a),
        .parallel_in (in_a),
        .serial_out  (ser_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    transmitter #(
        .data_length  (5),
        .dummy_period (1),
        .stop_bits    (2)
    ) u_b (
        .clk         (clk),
        .prst        (prst),
        .start       (start_b),
        .parallel_in (in_b),
        .serial_out  (ser_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         ser;
        bit         busy;
        bit         done;
        bit         st;
        bit         rst;
        logic [7:0] d;
    } ent_t;

    ent_t tl[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void tl_frame(input int dl, input int dp, input int sb,
                                     input logic [7:0] w);
        ent_t e;
        int   nb;
        nb     = 1 + dl + sb;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.st   = 1'b0;
        e.rst  = 1'b0;
        e.d    = w;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)
                e.ser = 1'b0;
            else if (b <= dl)
                e.ser = w[b-1];
            else
                e.ser = 1'b1;
            for (int c = 0; c < dp; c++) tl.push_back(e);
        end
    endfunction

    function automatic void tl_idle(input int n, input bit first_done,
                                    input logic [7:0] w);
        ent_t e;
        e.ser  = 1'b1;
        e.busy = 1'b0;
        e.st   = 1'b0;
        e.rst  = 1'b0;
        e.d    = w;
        for (int i = 0; i < n; i++) begin
            e.done = first_done && (i == 0);
            tl.push_back(e);
        end
    endfunction

    task automatic play(input int sel, input logic [7:0] w0, input string tag);
        if (sel == 0) begin
            start_a = 1'b1;
            in_a    = w0;
        end else begin
            start_b = 1'b1;
            in_b    = w0[4:0];
        end
        step();
        foreach (tl[k]) begin
            if (sel == 0) begin
                chk($sformatf("%s[%0d].ser", tag, k), ser_a, tl[k].ser);
                chk($sformatf("%s[%0d].busy", tag, k), busy_a, tl[k].busy);
                chk($sformatf("%s[%0d].done", tag, k), done_a, tl[k].done);
                start_a = tl[k].st;
                in_a    = tl[k].d;
            end else begin
                chk($sformatf("%s[%0d].ser", tag, k), ser_b, tl[k].ser);
                chk($sformatf("%s[%0d].busy", tag, k), busy_b, tl[k].busy);
                chk($sformatf("%s[%0d].done", tag, k), done_b, tl[k].done);
                start_b = tl[k].st;
                in_b    = tl[k].d[4:0];
            end
            prst = tl[k].rst;
            step();
        end
    endtask

    initial begin
        logic [7:0] w;
        int         n;

        prst    = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        in_a    = '0;
        in_b    = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d.ser_a", i), ser_a, 1'b1);
            chk($sformatf("rst%0d.busy_a", i), busy_a, 1'b0);
            chk($sformatf("rst%0d.done_a", i), done_a, 1'b0);
            chk($sformatf("rst%0d.ser_b", i), ser_b, 1'b1);
            chk($sformatf("rst%0d.busy_b", i), busy_b, 1'b0);
            chk($sformatf("rst%0d.done_b", i), done_b, 1'b0);
        end
        prst = 1'b0;
        step();

        // Single A5 frame with an ignored mid-frame request and new data.
        tl.delete();
        tl_frame(8, 5, 1, 8'hA5);
        for (int k = 20; k < tl.size(); k++) tl[k].d = 8'hFF;
        tl[20].st = 1'b1;
        tl_idle(6, 1'b1, 8'hFF);
        play(0, 8'hA5, "a5");

        // Back-to-back frames with start held high.
        tl.delete();
        tl_frame(8, 5, 1, 8'h00);
        foreach (tl[k]) tl[k].st = 1'b1;
        tl[49].d = 8'hFF;
        n = tl.size();
        tl_frame(8, 5, 1, 8'hFF);
        tl[n].done = 1'b1;
        tl_idle(3, 1'b1, 8'hFF);
        play(0, 8'h00, "b2b");

        // Reset during data bit 3, then a clean 3C frame.
        tl.delete();
        tl_frame(8, 5, 1, 8'h5A);
        while (tl.size() > 22) void'(tl.pop_back());
        tl[21].rst = 1'b1;
        tl_idle(4, 1'b0, 8'h5A);
        play(0, 8'h5A, "rstmid");

        tl.delete();
        tl_frame(8, 5, 1, 8'h3C);
        tl_idle(2, 1'b1, 8'h3C);
        play(0, 8'h3C, "x3c");

        for (int r = 0; r < 3; r++) begin
            w = 8'($urandom);
            tl.delete();
            tl_frame(8, 5, 1, w);
            tl_idle(2, 1'b1, w);
            play(0, w, $sformatf("rnda%0d", r));
        end

        // Corner instance: one cycle per bit, two stop bits, 5 data bits.
        tl.delete();
        tl_frame(5, 1, 2, 8'h13);
        tl_idle(3, 1'b1, 8'h13);
        play(1, 8'h13, "b13");

        for (int r = 0; r < 4; r++) begin
            w = {3'b000, 5'($urandom)};
            tl.delete();
            tl_frame(5, 1, 2, w);
            tl_idle(2, 1'b1, w);
            play(1, w, $sformatf("rndb%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
